// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one cacheline memory port between the icache (read-only)
// and the dcache (read + write-back). Simultaneous requests are resolved
// round-robin. The granted command is latched and held until mem_resp, and the
// response is routed back only to the owner.
//
// state  | meaning
// IDLE   | no transaction outstanding, arbitration happens here only
// I_BUSY | icache owns memory, waiting for mem_resp
// D_BUSY | dcache owns memory, waiting for mem_resp
module pmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_d_q, last_d_d;   // 1: dcache holds the most recent grant
  logic                  cmd_read_q, cmd_read_d;
  logic                  cmd_write_q, cmd_write_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [LINE_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;

  logic i_req, d_req, grant_i, grant_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // On a tie the requester that did not win last time is served.
  assign grant_i = (state_q == IDLE) && i_req && (!d_req || last_d_q);
  assign grant_d = (state_q == IDLE) && d_req && (!i_req || !last_d_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: grant from IDLE, return to IDLE on the memory response
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_i)      state_d = I_BUSY;
        else if (grant_d) state_d = D_BUSY;
      end
      I_BUSY, D_BUSY: begin
        if (mem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command capture on grant, command strobes cleared on completion
  always_comb begin
    last_d_d    = last_d_q;
    cmd_read_d  = cmd_read_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    if (grant_i) begin
      last_d_d    = 1'b0;
      cmd_read_d  = 1'b1;
      cmd_write_d = 1'b0;
      cmd_addr_d  = i_pmem_address;
      cmd_wdata_d = '0;
    end else if (grant_d) begin
      // read+write together is illegal; the write-back wins
      last_d_d    = 1'b1;
      cmd_read_d  = ~d_pmem_write;
      cmd_write_d = d_pmem_write;
      cmd_addr_d  = d_pmem_address;
      cmd_wdata_d = d_pmem_wdata;
    end else if ((state_q != IDLE) && mem_resp) begin
      cmd_read_d  = 1'b0;
      cmd_write_d = 1'b0;
    end
  end

  // Command registers feed the memory port directly
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d_q    <= 1'b0;
      cmd_read_q  <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else begin
      last_d_q    <= last_d_d;
      cmd_read_q  <= cmd_read_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

  // Response routing: only the current owner sees mem_resp
  always_comb begin
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    case (state_q)
      I_BUSY:  i_pmem_resp = mem_resp;
      D_BUSY:  d_pmem_resp = mem_resp;
      default: ;
    endcase
  end

  assign mem_read     = cmd_read_q;
  assign mem_write    = cmd_write_q;
  assign mem_address  = cmd_addr_q;
  assign mem_wdata    = cmd_wdata_q;
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

  // Flag the illegal simultaneous dcache read and write
  always @(posedge clk) begin
    assert (rst || !(d_pmem_read && d_pmem_write))
      else $error("pmem_arbiter: d_pmem_read and d_pmem_write asserted together");
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Testbench for pmem_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_pmem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: who owns memory and which command it issued.
  // owner: 0 none, 1 icache, 2 dcache
  int            m_owner;
  bit            m_last_was_d;
  bit            m_rd, m_wr;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;

  task automatic model_reset();
    m_owner = 0; m_last_was_d = 0;
    m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
  endtask

  // Applied at every rising edge with the inputs that were present there.
  task automatic model_edge();
    bit iw, dw;
    if (rst) begin
      model_reset();
    end else if (m_owner != 0) begin
      if (mem_resp) begin
        m_owner = 0; m_rd = 0; m_wr = 0;
      end
    end else begin
      iw = i_pmem_read;
      dw = d_pmem_read | d_pmem_write;
      if (iw && (!dw || m_last_was_d)) begin
        m_owner = 1; m_last_was_d = 0;
        m_rd = 1; m_wr = 0; m_addr = i_pmem_address; m_wdata = '0;
      end else if (dw) begin
        m_owner = 2; m_last_was_d = 1;
        m_wr = d_pmem_write; m_rd = !d_pmem_write;
        m_addr = d_pmem_address; m_wdata = d_pmem_wdata;
      end
    end
  endtask

  task automatic check_cycle();
    chk("mem_read",    mem_read,    m_rd);
    chk("mem_write",   mem_write,   m_wr);
    chk("mem_address", mem_address, m_addr);
    chk("mem_wdata",   mem_wdata,   m_wdata);
    chk("i_resp",      i_pmem_resp, (m_owner == 1) && mem_resp);
    chk("d_resp",      d_pmem_resp, (m_owner == 2) && mem_resp);
    chk("i_rdata",     i_pmem_rdata, mem_rdata);
    chk("d_rdata",     d_pmem_rdata, mem_rdata);
  endtask

  // One clock: inputs are already set (after a falling edge).
  task automatic step();
    #1;
    check_cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; i_pmem_read = 0; i_pmem_address = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    mem_rdata = '0; mem_resp = 0;
  endtask

  task automatic do_reset();
    rst = 1; mem_resp = 0;
    step();
    rst = 0;
  endtask

  task automatic wait_busy();
    bit ok;
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      if (mem_read || mem_write) begin ok = 1; break; end
      step();
    end
    if (!ok) chk("wait_busy_timeout", 0, 1);
  endtask

  task automatic finish_txn(input int lat, input logic [LW-1:0] rdata);
    mem_resp = 0;
    repeat (lat) step();
    mem_resp = 1; mem_rdata = rdata;
    step();
    mem_resp = 0;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int w = 0; w < LW / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  logic [LW-1:0] line_aa, line_55;

  initial begin
    line_aa = {(LW/8){8'hAA}};
    line_55 = {(LW/8){8'h55}};
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    chk("reset_mem_read",  mem_read, 0);
    chk("reset_mem_write", mem_write, 0);
    chk("reset_mem_addr",  mem_address, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    rst = 0;

    // idle for 5 cycles
    repeat (5) step();

    // icache read alone, resp after 4 cycles
    i_pmem_read = 1; i_pmem_address = 32'h0000_1000;
    step();
    chk("i_read_cyc1", mem_read, 1);
    chk("i_read_addr", mem_address, 32'h0000_1000);
    repeat (3) step();
    mem_resp = 1; mem_rdata = line_aa;
    #1;
    chk("i_resp_pulse", i_pmem_resp, 1);
    chk("i_rdata_aa", i_pmem_rdata, line_aa);
    chk("d_resp_quiet", d_pmem_resp, 0);
    i_pmem_read = 0;
    step();
    mem_resp = 0;
    chk("i_read_dropped", mem_read, 0);
    step();

    // dcache write-back with address changing mid-transaction
    d_pmem_write = 1; d_pmem_address = 32'h0000_2040; d_pmem_wdata = line_55;
    step();
    d_pmem_address = 32'h0000_9990; d_pmem_wdata = '0;
    for (int k = 0; k < 3; k++) begin
      chk("wb_mem_write", mem_write, 1);
      chk("wb_addr_held", mem_address, 32'h0000_2040);
      chk("wb_wdata_held", mem_wdata, line_55);
      step();
    end
    d_pmem_write = 0;
    finish_txn(0, rand_line());
    step();

    // simultaneous requests from reset: D, I, D, I, D, I
    do_reset();
    i_pmem_read = 1; i_pmem_address = 32'h0000_0100;
    d_pmem_read = 1; d_pmem_address = 32'h0000_0200;
    for (int t = 0; t < 6; t++) begin
      wait_busy();
      chk("rr_grant_addr", mem_address, (t % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100);
      finish_txn(2, rand_line());
    end
    idle_inputs();
    step();

    // dcache write-back then fill held through resp, icache also waiting
    do_reset();
    i_pmem_read = 1; i_pmem_address = 32'h0000_0300;
    d_pmem_write = 1; d_pmem_address = 32'h0000_0400; d_pmem_wdata = line_55;
    wait_busy();
    chk("wbf_first_write", mem_write, 1);
    chk("wbf_first_addr", mem_address, 32'h0000_0400);
    repeat (2) step();
    d_pmem_write = 0; d_pmem_read = 1;
    finish_txn(0, rand_line());
    wait_busy();
    chk("wbf_then_i_addr", mem_address, 32'h0000_0300);
    chk("wbf_then_i_read", mem_read, 1);
    step();
    i_pmem_read = 0;
    finish_txn(0, line_aa);
    wait_busy();
    chk("wbf_fill_addr", mem_address, 32'h0000_0400);
    chk("wbf_fill_read", mem_read, 1);
    chk("wbf_fill_nowr", mem_write, 0);
    d_pmem_read = 0;
    finish_txn(1, rand_line());
    step();

    // reset during D_BUSY abandons the transaction
    d_pmem_write = 1; d_pmem_address = 32'h0000_0500; d_pmem_wdata = line_55;
    wait_busy();
    step();
    rst = 1;
    step();
    rst = 0; d_pmem_write = 0;
    chk("rst_mid_mem_write", mem_write, 0);
    mem_resp = 1;
    #1;
    chk("rst_mid_no_d_resp", d_pmem_resp, 0);
    step();
    mem_resp = 0;
    i_pmem_read = 1; i_pmem_address = 32'h0000_0600;
    d_pmem_read = 1; d_pmem_address = 32'h0000_0700;
    wait_busy();
    chk("rst_last_grant_i", mem_address, 32'h0000_0700);
    finish_txn(1, rand_line());
    idle_inputs();
    step();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int dsel;
      rst = ($urandom_range(0, 99) == 0);
      i_pmem_read = $urandom_range(0, 1);
      i_pmem_address = $urandom;
      dsel = $urandom_range(0, 2);
      d_pmem_read = (dsel == 1);
      d_pmem_write = (dsel == 2);
      d_pmem_address = $urandom;
      d_pmem_wdata = rand_line();
      mem_resp = ($urandom_range(0, 3) == 0);
      mem_rdata = rand_line();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
